// File: rtl/snake_pkg.sv
// Shared types and default timing constants for the snake game controller.
// game_sequencer and the draw block both consume game_mode_t.
package snake_pkg;

    typedef enum logic [1:0] {
        MENU,
        COUNTDOWN,
        GAME,
        RESULT
    } game_mode_t;

    typedef enum logic [2:0] {
        NONE,
        WON,
        LOST,
        DRAW,
        ERROR
    } result_t;

    typedef enum logic [2:0] {
        S_MENU,
        S_SYNC,
        S_COUNTDOWN,
        S_RUN,
        S_RESULT
    } seq_state_t;

    localparam int DEF_COUNTDOWN_TICKS    = 3;
    localparam int DEF_RESULT_TICKS       = 20;
    localparam int DEF_SYNC_TIMEOUT_TICKS = 50;
    localparam int DEF_CNT_W              = 6;

    // Clamp a remaining-tick count into the 2-bit countdown display range.
    function automatic logic [1:0] sat2(input int v);
        logic [1:0] r;
        if (v <= 0) begin
            r = 2'd0;
        end else if (v >= 3) begin
            r = 2'd3;
        end else begin
            r = v[1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/game_sequencer_tick_edge.sv
// Rising-edge detector on the divided game tick plus the per-state tick counter.
// hit fires on the tick_p that brings the counter up to limit.
module tick_edge
    import snake_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tick_p,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
        end
    end

    assign tick_p = tick_in & ~tick_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (tick_p) begin
            count <= count + ONE;
        end
    end

    assign hit = tick_p && ((count + ONE) == limit);

endmodule

// File: rtl/game_sequencer.sv
// Match sequencer: menu, peer handshake, countdown, running game, result screen.
//   state       | meaning
//   S_MENU      | idle, waiting for a start click
//   S_SYNC      | local side ready, waiting for the peer (with timeout)
//   S_COUNTDOWN | map loaded, counting down to play
//   S_RUN       | game running, one move per tick
//   S_RESULT    | outcome shown for a fixed number of ticks
module game_sequencer
    import snake_pkg::*;
#(
    parameter int COUNTDOWN_TICKS    = DEF_COUNTDOWN_TICKS,
    parameter int RESULT_TICKS       = DEF_RESULT_TICKS,
    parameter int SYNC_TIMEOUT_TICKS = DEF_SYNC_TIMEOUT_TICKS,
    parameter int CNT_W              = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       peer_ready,
    input  logic       com_err,
    input  logic       won,
    input  logic       lost,
    input  logic       draw_in,
    output game_mode_t mode,
    output logic       move_en,
    output logic       map_init,
    output logic       local_ready,
    output logic [1:0] countdown,
    output result_t    result
);

    seq_state_t       state;
    seq_state_t       state_next;
    result_t          result_next;
    logic             move_en_next;
    logic             map_init_next;
    logic             sample_q;
    logic             tick_p;
    logic             hit;
    logic             cnt_clr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit;

    always_comb begin
        limit = '0;
        case (state)
            S_SYNC:      limit = CNT_W'(SYNC_TIMEOUT_TICKS);
            S_COUNTDOWN: limit = CNT_W'(COUNTDOWN_TICKS);
            S_RESULT:    limit = CNT_W'(RESULT_TICKS);
            default:     limit = '0;
        endcase
    end

    // MENU and RUN never use the counter, so hold it at zero there.
    assign cnt_clr = (state_next != state) || (state == S_MENU) || (state == S_RUN);

    tick_edge #(
        .CNT_W (CNT_W)
    ) u_tick_edge (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .clr     (cnt_clr),
        .limit   (limit),
        .tick_p  (tick_p),
        .count   (count),
        .hit     (hit)
    );

    always_comb begin
        state_next    = state;
        result_next   = result;
        map_init_next = 1'b0;
        move_en_next  = 1'b0;
        case (state)
            S_MENU: begin
                if (start) begin
                    state_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (peer_ready) begin
                    state_next    = S_COUNTDOWN;
                    map_init_next = 1'b1;
                    result_next   = NONE;
                end else if (hit) begin
                    state_next  = S_MENU;
                    result_next = NONE;
                end
            end
            S_COUNTDOWN: begin
                if (!peer_ready) begin
                    state_next  = S_MENU;
                    result_next = ERROR;
                end else if (hit) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Link loss outranks a collision result from the same cycle.
                if (com_err || !peer_ready) begin
                    state_next  = S_RESULT;
                    result_next = ERROR;
                end else if (sample_q && (draw_in || (won && lost))) begin
                    state_next  = S_RESULT;
                    result_next = DRAW;
                end else if (sample_q && won) begin
                    state_next  = S_RESULT;
                    result_next = WON;
                end else if (sample_q && lost) begin
                    state_next  = S_RESULT;
                    result_next = LOST;
                end
            end
            S_RESULT: begin
                if (hit) begin
                    state_next = S_MENU;
                end
            end
            default: begin
                state_next = S_MENU;
            end
        endcase
        move_en_next = (state == S_RUN) && (state_next == S_RUN) && tick_p;
    end

    // sample_q marks the cycle after a move, when won/lost/draw_in describe that step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_MENU;
            result   <= NONE;
            move_en  <= 1'b0;
            map_init <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            state    <= state_next;
            result   <= result_next;
            move_en  <= move_en_next;
            map_init <= map_init_next;
            sample_q <= move_en;
        end
    end

    always_comb begin
        mode        = MENU;
        local_ready = 1'b0;
        countdown   = 2'd0;
        case (state)
            S_MENU: begin
                mode = MENU;
            end
            S_SYNC: begin
                mode        = MENU;
                local_ready = 1'b1;
            end
            S_COUNTDOWN: begin
                mode        = COUNTDOWN;
                local_ready = 1'b1;
                countdown   = sat2(COUNTDOWN_TICKS - int'(count));
            end
            S_RUN: begin
                mode        = GAME;
                local_ready = 1'b1;
            end
            S_RESULT: begin
                mode = RESULT;
            end
            default: begin
                mode = MENU;
            end
        endcase
    end

endmodule
